rf_scoreboard: RTL and testbench

// Issue controller for the 32-entry register file stage. Tracks in-flight writes
// per architectural register and withholds an instruction from issue until its

---
 rtl/rf_scoreboard.sv | 190 +++++++++++++++++++
 tb/tb_rf_scoreboard.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_scoreboard.sv
// Register-file issue scoreboard: tracks in-flight writes per architectural register
// and holds decode back until sources are settled; flush drains outstanding writebacks.
module rf_scoreboard #(
    parameter int NREGS       = 32,
    parameter int CNT_W       = 2,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   dec_valid,
    output logic                   dec_ready,
    input  logic [4:0]             dec_rs1_sel,
    input  logic [4:0]             dec_rs2_sel,
    input  logic [4:0]             dec_rd_sel,
    input  logic                   dec_uses_rs1,
    input  logic                   dec_uses_rs2,
    input  logic                   dec_writes_rd,
    input  logic                   issue_ready,
    output logic                   issue_valid,
    input  logic                   wb_enable,
    input  logic [4:0]             wb_addr,
    input  logic                   flush,
    output logic [NREGS-1:0]       busy_mask,
    output logic                   drain_busy,
    output logic                   wb_err,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0]       CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]       CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]       CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] STALL_ONE  = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STALL_CNT_W-1:0] STALL_SAT  = {STALL_CNT_W{1'b1}};
    localparam logic [NREGS-1:0]       ONEHOT_LSB = {{(NREGS-1){1'b0}}, 1'b1};

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q [NREGS];
    logic [CNT_W-1:0]         cnt_d [NREGS];
    logic                     wb_err_q, wb_err_d;
    logic [STALL_CNT_W-1:0]   stall_q, stall_d;
    logic                     hazard_s;
    logic                     fire_s;
    logic                     wb_live_s;
    logic [NREGS-1:0]         inc_vec_s;
    logic [NREGS-1:0]         dec_vec_s;
    logic                     all_zero_d;

    // Hazard check against registered counters only; a same-cycle writeback lands at the edge.
    always_comb begin
        hazard_s = 1'b0;
        if (dec_uses_rs1 && (dec_rs1_sel != 5'd0) && (cnt_q[dec_rs1_sel] != CNT_ZERO)) begin
            hazard_s = 1'b1;
        end else if (dec_uses_rs2 && (dec_rs2_sel != 5'd0) && (cnt_q[dec_rs2_sel] != CNT_ZERO)) begin
            hazard_s = 1'b1;
        end else if (dec_writes_rd && (dec_rd_sel != 5'd0) && (cnt_q[dec_rd_sel] == CNT_MAX)) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
    end

    // Issue handshake: only in RUN, and never in the cycle a flush arrives.
    always_comb begin
        issue_valid = 1'b0;
        dec_ready   = 1'b0;
        if ((state_q == ST_RUN) && !flush) begin
            issue_valid = dec_valid & ~hazard_s;
            dec_ready   = issue_ready & ~hazard_s;
        end else begin
            issue_valid = 1'b0;
            dec_ready   = 1'b0;
        end
    end

    assign fire_s    = dec_valid & dec_ready;
    assign wb_live_s = wb_enable & (wb_addr != 5'd0);

    // One-hot increment/decrement requests; x0 is never tracked.
    always_comb begin
        inc_vec_s = {NREGS{1'b0}};
        dec_vec_s = {NREGS{1'b0}};
        if (fire_s && dec_writes_rd && (dec_rd_sel != 5'd0)) begin
            inc_vec_s = ONEHOT_LSB << dec_rd_sel;
        end else begin
            inc_vec_s = {NREGS{1'b0}};
        end
        if (wb_live_s && (cnt_q[wb_addr] != CNT_ZERO)) begin
            dec_vec_s = ONEHOT_LSB << wb_addr;
        end else begin
            dec_vec_s = {NREGS{1'b0}};
        end
    end

    // Counter next-state; simultaneous inc and dec on one register cancel.
    always_comb begin
        all_zero_d = 1'b1;
        for (int i = 0; i < NREGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (inc_vec_s[i] && !dec_vec_s[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (!inc_vec_s[i] && dec_vec_s[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
            if (cnt_d[i] != CNT_ZERO) begin
                all_zero_d = 1'b0;
            end else begin
                all_zero_d = all_zero_d;
            end
        end
    end

    // Sticky error and saturating stall counter.
    always_comb begin
        wb_err_d = wb_err_q;
        stall_d  = stall_q;
        if (wb_live_s && (cnt_q[wb_addr] == CNT_ZERO)) begin
            wb_err_d = 1'b1;
        end else begin
            wb_err_d = wb_err_q;
        end
        if (dec_valid && !dec_ready && (stall_q != STALL_SAT)) begin
            stall_d = stall_q + STALL_ONE;
        end else begin
            stall_d = stall_q;
        end
    end

    // Run/drain FSM; DRAIN exits once every counter is zero after this cycle's update.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (flush) begin
                    state_d = ST_DRAIN;
                end else if (all_zero_d) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_RUN;
            wb_err_q <= 1'b0;
            stall_q  <= {STALL_CNT_W{1'b0}};
            for (int i = 0; i < NREGS; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            state_q  <= state_d;
            wb_err_q <= wb_err_d;
            stall_q  <= stall_d;
            for (int i = 0; i < NREGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Status outputs are pure functions of registered state.
    always_comb begin
        busy_mask = {NREGS{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            busy_mask[i] = (cnt_q[i] != CNT_ZERO);
        end
    end

    assign drain_busy   = (state_q == ST_DRAIN);
    assign wb_err       = wb_err_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: directed scenarios plus random traffic
// compared every cycle against a per-register pending-write count model.
module tb_rf_scoreboard;

    logic        clk = 1'b0;
    logic        resetn;
    logic        dec_valid, dec_ready;
    logic [4:0]  dec_rs1_sel, dec_rs2_sel, dec_rd_sel;
    logic        dec_uses_rs1, dec_uses_rs2, dec_writes_rd;
    logic        issue_ready, issue_valid;
    logic        wb_enable;
    logic [4:0]  wb_addr;
    logic        flush;
    logic [31:0] busy_mask;
    logic        drain_busy, wb_err;
    logic [31:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    // reference model: outstanding writes per register, drain flag, error, stall count
    int          m_cnt [32];
    bit          m_drain;
    bit          m_err;
    logic [31:0] m_stall;

    always #5 clk = ~clk;

    rf_scoreboard #(.NREGS(32), .CNT_W(2), .STALL_CNT_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1_sel(dec_rs1_sel), .dec_rs2_sel(dec_rs2_sel), .dec_rd_sel(dec_rd_sel),
        .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2), .dec_writes_rd(dec_writes_rd),
        .issue_ready(issue_ready), .issue_valid(issue_valid),
        .wb_enable(wb_enable), .wb_addr(wb_addr), .flush(flush),
        .busy_mask(busy_mask), .drain_busy(drain_busy), .wb_err(wb_err),
        .stall_cycles(stall_cycles)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_hazard();
        bit h = 1'b0;
        if (dec_uses_rs1 && dec_rs1_sel != 5'd0 && m_cnt[dec_rs1_sel] != 0) h = 1'b1;
        if (dec_uses_rs2 && dec_rs2_sel != 5'd0 && m_cnt[dec_rs2_sel] != 0) h = 1'b1;
        if (dec_writes_rd && dec_rd_sel != 5'd0 && m_cnt[dec_rd_sel] == 3) h = 1'b1;
        return h;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b = 32'd0;
        for (int i = 0; i < 32; i++) b[i] = (m_cnt[i] != 0);
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_drain = 1'b0;
        m_err   = 1'b0;
        m_stall = 32'd0;
    endtask

    task automatic idle();
        dec_valid = 1'b0; dec_rs1_sel = 5'd0; dec_rs2_sel = 5'd0; dec_rd_sel = 5'd0;
        dec_uses_rs1 = 1'b0; dec_uses_rs2 = 1'b0; dec_writes_rd = 1'b0;
        issue_ready = 1'b1; wb_enable = 1'b0; wb_addr = 5'd0; flush = 1'b0;
    endtask

    task automatic set_dec(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                           input logic u2, input logic [4:0] rd, input logic w);
        dec_valid = 1'b1;
        dec_rs1_sel = rs1; dec_uses_rs1 = u1;
        dec_rs2_sel = rs2; dec_uses_rs2 = u2;
        dec_rd_sel = rd;   dec_writes_rd = w;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] a);
        wb_enable = en; wb_addr = a;
    endtask

    // Called just after a falling edge with inputs applied: compare, then advance model at the rising edge.
    task automatic cycle();
        bit h, er, ev, fire;
        int nc [32];
        #2;
        h = m_hazard();
        if (!m_drain && !flush) begin
            ev = dec_valid && !h;
            er = issue_ready && !h;
        end else begin
            ev = 1'b0;
            er = 1'b0;
        end
        check("issue_valid", issue_valid, ev);
        check("dec_ready", dec_ready, er);
        check("busy_mask", busy_mask, m_busy());
        check("drain_busy", drain_busy, m_drain);
        check("wb_err", wb_err, m_err);
        check("stall_cycles", stall_cycles, m_stall);
        fire = dec_valid && er;
        @(posedge clk);
        nc = m_cnt;
        if (dec_valid && !er && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
        if (fire && dec_writes_rd && dec_rd_sel != 5'd0) nc[dec_rd_sel] = nc[dec_rd_sel] + 1;
        if (wb_enable && wb_addr != 5'd0) begin
            if (m_cnt[wb_addr] == 0) m_err = 1'b1;
            else nc[wb_addr] = nc[wb_addr] - 1;
        end
        if (!m_drain) begin
            m_drain = flush;
        end else if (!flush) begin
            m_drain = 1'b0;
            for (int i = 0; i < 32; i++) if (nc[i] != 0) m_drain = 1'b1;
        end
        m_cnt = nc;
        @(negedge clk);
    endtask

    task automatic reset_check(input string tag);
        resetn = 1'b0;
        model_reset();
        #2;
        check({tag, "_busy"}, busy_mask, 32'd0);
        check({tag, "_drain"}, {31'd0, drain_busy}, 32'd0);
        check({tag, "_err"}, {31'd0, wb_err}, 32'd0);
        check({tag, "_stall"}, stall_cycles, 32'd0);
        @(negedge clk);
        idle();
        resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        idle();
        resetn = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_check("reset_init");

        // RAW: rd=5 in flight blocks a reader until writeback lands
        set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1); cycle();
        check("raw_busy5", busy_mask, 32'h0000_0020);
        set_dec(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1); cycle();
        set_wb(1'b1, 5'd5);
        #1 check("raw_same_cycle_wb", {31'd0, dec_ready}, 32'd0);
        cycle();
        set_wb(1'b0, 5'd0);
        #1 check("raw_ready_after_wb", {31'd0, dec_ready}, 32'd1);
        cycle();
        idle(); set_wb(1'b1, 5'd6); cycle(); idle();

        // WAW saturation on x7
        repeat (3) begin set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1); cycle(); end
        check("waw_busy7", busy_mask, 32'h0000_0080);
        #1 check("waw_4th_stall", {31'd0, dec_ready}, 32'd0);
        set_wb(1'b1, 5'd7); cycle();
        set_wb(1'b0, 5'd0);
        #1 check("waw_4th_issue", {31'd0, issue_valid}, 32'd1);
        cycle();
        idle(); set_wb(1'b1, 5'd7);
        repeat (3) cycle();
        idle(); cycle();
        check("waw_clean", busy_mask, 32'd0);

        // Simultaneous issue and writeback on x9
        set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1); cycle();
        set_wb(1'b1, 5'd9); cycle();
        idle(); cycle();
        check("simul_busy9", busy_mask, 32'h0000_0200);
        set_wb(1'b1, 5'd9); cycle(); idle();

        // x0 writes are untracked; writeback to an idle register is an error
        set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1); cycle();
        check("x0_untracked", busy_mask, 32'd0);
        idle(); set_wb(1'b1, 5'd0); cycle();
        check("x0_wb_no_err", {31'd0, wb_err}, 32'd0);
        set_wb(1'b1, 5'd3); cycle();
        idle(); repeat (3) cycle();
        check("wb_err_sticky", {31'd0, wb_err}, 32'd1);

        // Flush with x4 pending: drain until its writeback
        set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1); cycle();
        set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1); flush = 1'b1;
        #1 check("flush_blocks", {31'd0, dec_ready}, 32'd0);
        cycle();
        flush = 1'b0;
        repeat (3) cycle();
        check("drain_busy_held", {31'd0, drain_busy}, 32'd1);
        set_wb(1'b1, 5'd4); cycle();
        idle(); cycle();
        check("drain_exit", {31'd0, drain_busy}, 32'd0);
        flush = 1'b1; cycle();
        flush = 1'b0; cycle();
        check("flush_empty_exit", {31'd0, drain_busy}, 32'd0);

        // Random traffic over a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            dec_valid     = ($urandom_range(0, 3) != 0);
            dec_rs1_sel   = 5'($urandom_range(0, 7));
            dec_rs2_sel   = 5'($urandom_range(0, 7));
            dec_rd_sel    = 5'($urandom_range(0, 7));
            dec_uses_rs1  = 1'($urandom_range(0, 1));
            dec_uses_rs2  = 1'($urandom_range(0, 1));
            dec_writes_rd = ($urandom_range(0, 3) != 0);
            issue_ready   = ($urandom_range(0, 4) != 0);
            wb_enable     = ($urandom_range(0, 2) == 0);
            wb_addr       = 5'($urandom_range(0, 7));
            flush         = ($urandom_range(0, 40) == 0);
            cycle();
        end

        reset_check("reset_mid_traffic");
        idle(); cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
